// File: rtl/rgb_gray_pipe_pkg.sv
// Shared types and Q10 constants for the RGB->grey pipe.
// Coefficient sets are Q10 and each set sums to 1024, so a full-scale white pixel maps to full-scale grey.
package rgb_gray_pkg;

  localparam int MODE_W    = 2;
  localparam int COEF_W    = 11;
  localparam int Q10_HALF  = 512;
  localparam int Q10_SHIFT = 10;

  typedef enum logic [MODE_W-1:0] {
    MODE_601  = 2'd0,
    MODE_709  = 2'd1,
    MODE_MEAN = 2'd2,
    MODE_G    = 2'd3
  } mode_e;

  typedef struct packed {
    logic [COEF_W-1:0] r;
    logic [COEF_W-1:0] g;
    logic [COEF_W-1:0] b;
  } coef_t;

  localparam coef_t COEF_601  = '{r: 11'd306, g: 11'd601,  b: 11'd117};
  localparam coef_t COEF_709  = '{r: 11'd218, g: 11'd732,  b: 11'd74};
  localparam coef_t COEF_MEAN = '{r: 11'd341, g: 11'd342,  b: 11'd341};
  localparam coef_t COEF_G    = '{r: 11'd0,   g: 11'd1024, b: 11'd0};

  function automatic coef_t coef_of(input mode_e m);
    case (m)
      MODE_601:  coef_of = COEF_601;
      MODE_709:  coef_of = COEF_709;
      MODE_MEAN: coef_of = COEF_MEAN;
      default:   coef_of = COEF_G;
    endcase
  endfunction

endpackage

// File: rtl/rgb_gray_pipe_if.sv
// Video-in / grey-out bundle for rgb_gray_pipe.
// master drives pixels and mode, slave (the converter) returns grey samples and markers.
interface rgb_gray_pipe_if
  import rgb_gray_pkg::*;
#(
  parameter int DW = 8,
  parameter int CW = 11
);
  logic              i_vs;
  logic              data_de;
  logic [DW-1:0]     data_r;
  logic [DW-1:0]     data_g;
  logic [DW-1:0]     data_b;
  logic [MODE_W-1:0] i_mode;
  logic              o_de;
  logic [DW-1:0]     o_gray;
  logic [CW-1:0]     o_pix_x;
  logic [CW-1:0]     o_pix_y;
  logic              o_sof;
  logic              o_eol;
  logic              o_err;

  modport master (
    output i_vs, data_de, data_r, data_g, data_b, i_mode,
    input  o_de, o_gray, o_pix_x, o_pix_y, o_sof, o_eol, o_err
  );

  modport slave (
    input  i_vs, data_de, data_r, data_g, data_b, i_mode,
    output o_de, o_gray, o_pix_x, o_pix_y, o_sof, o_eol, o_err
  );
endinterface

// File: rtl/rgb_gray_pipe_coord.sv
// Input-side pixel coordinate tracker with vsync edge detect and timing-error pulse.
// A vsync rising edge wins over any increment; a beat on that edge keeps the old coordinate.
module pix_coord_cnt #(
  parameter int H_ACT = 1280,
  parameter int V_ACT = 800,
  parameter int CW    = 11
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          vs,
  input  logic          de,
  output logic [CW-1:0] x,
  output logic [CW-1:0] y,
  output logic          vs_rise,
  output logic          err
);
  logic vs_d;
  logic de_d;
  logic last_x;
  logic last_y;
  logic short_line;
  logic frame_err;

  assign vs_rise    = vs & ~vs_d;
  assign last_x     = (x == CW'(H_ACT - 1));
  assign last_y     = (y == CW'(V_ACT - 1));
  assign short_line = de_d & ~de & (x != '0);
  assign frame_err  = vs_rise & ((x != '0) | (y != '0));

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      vs_d <= 1'b0;
      de_d <= 1'b0;
      err  <= 1'b0;
      x    <= '0;
      y    <= '0;
    end else begin
      vs_d <= vs;
      de_d <= de;
      err  <= short_line | frame_err;
      if (vs_rise) begin
        x <= '0;
        y <= '0;
      end else if ((de && last_x) || short_line) begin
        x <= '0;
        y <= last_y ? '0 : y + CW'(1);
      end else if (de) begin
        x <= x + CW'(1);
      end
    end
  end

endmodule

// File: rtl/rgb_gray_pipe.sv
// Three-stage RGB->grey converter with frame-latched coefficient mode and output-aligned coordinates.
// Stages: products, sum, round/saturate; flags ride alongside the data.
module rgb_gray_pipe
  import rgb_gray_pkg::*;
#(
  parameter int DW    = 8,
  parameter int H_ACT = 1280,
  parameter int V_ACT = 800,
  parameter int CW    = 11
) (
  input logic            i_pix_clk,
  input logic            rst_n,
  rgb_gray_pipe_if.slave bus
);
  localparam int PW = DW + 11;
  localparam int SW = DW + 12;
  localparam logic [SW-1:0] MAX_GRAY = SW'((2 ** DW) - 1);

  mode_e         mode_q;
  coef_t         coef;
  logic [CW-1:0] x_cur, y_cur;
  logic          vs_rise;
  logic          err;

  logic [PW-1:0] prod_r, prod_g, prod_b;
  logic          de1, de2;
  logic [CW-1:0] x1, y1, x2, y2;
  logic [SW-1:0] sum;
  logic [SW-1:0] rounded;
  logic [SW-1:0] shifted;
  logic [DW-1:0] gray_sat;

  pix_coord_cnt #(.H_ACT(H_ACT), .V_ACT(V_ACT), .CW(CW)) u_coord (
    .clk     (i_pix_clk),
    .rst_n   (rst_n),
    .vs      (bus.i_vs),
    .de      (bus.data_de),
    .x       (x_cur),
    .y       (y_cur),
    .vs_rise (vs_rise),
    .err     (err)
  );

  assign bus.o_err = err;

  // The beat coincident with the vsync edge still uses the previous frame's mode.
  always_ff @(posedge i_pix_clk) begin
    if (!rst_n)       mode_q <= MODE_601;
    else if (vs_rise) mode_q <= mode_e'(bus.i_mode);
  end

  assign coef = coef_of(mode_q);

  always_ff @(posedge i_pix_clk) begin
    if (!rst_n) begin
      de1    <= 1'b0;
      x1     <= '0;
      y1     <= '0;
      prod_r <= '0;
      prod_g <= '0;
      prod_b <= '0;
      de2    <= 1'b0;
      x2     <= '0;
      y2     <= '0;
      sum    <= '0;
    end else begin
      de1    <= bus.data_de;
      x1     <= x_cur;
      y1     <= y_cur;
      prod_r <= PW'(bus.data_r) * PW'(coef.r);
      prod_g <= PW'(bus.data_g) * PW'(coef.g);
      prod_b <= PW'(bus.data_b) * PW'(coef.b);
      de2    <= de1;
      x2     <= x1;
      y2     <= y1;
      sum    <= SW'(prod_r) + SW'(prod_g) + SW'(prod_b);
    end
  end

  assign rounded  = sum + SW'(Q10_HALF);
  assign shifted  = rounded >> Q10_SHIFT;
  assign gray_sat = (shifted > MAX_GRAY) ? '1 : shifted[DW-1:0];

  always_ff @(posedge i_pix_clk) begin
    if (!rst_n) begin
      bus.o_de    <= 1'b0;
      bus.o_gray  <= '0;
      bus.o_pix_x <= '0;
      bus.o_pix_y <= '0;
      bus.o_sof   <= 1'b0;
      bus.o_eol   <= 1'b0;
    end else begin
      bus.o_de  <= de2;
      bus.o_sof <= de2 && (x2 == '0) && (y2 == '0);
      bus.o_eol <= de2 && (x2 == CW'(H_ACT - 1));
      if (de2) begin
        bus.o_gray  <= gray_sat;
        bus.o_pix_x <= x2;
        bus.o_pix_y <= y2;
      end
    end
  end

endmodule

// File: tb/tb_rgb_gray_pipe.sv
// Directed bench for rgb_gray_pipe on a reduced 16x8 raster.
// Expected grey values are hand-computed per mode; coordinates are supplied by each step.
module tb_rgb_gray_pipe;
  localparam int H = 16;
  localparam int V = 8;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  rgb_gray_pipe_if #(.DW(8), .CW(5)) bus ();

  rgb_gray_pipe #(.DW(8), .H_ACT(H), .V_ACT(V), .CW(5)) dut (
    .i_pix_clk (clk),
    .rst_n     (rst_n),
    .bus       (bus)
  );

  int n_cmp = 0;
  int n_err = 0;
  int n_sof, n_eol, n_errp;
  int exp_mode;

  // Pixel set: white, (100,50,200), black, (10,20,30); grey per mode hand-computed.
  logic [7:0] pr [4] = '{8'd255, 8'd100, 8'd0, 8'd10};
  logic [7:0] pg [4] = '{8'd255, 8'd50,  8'd0, 8'd20};
  logic [7:0] pb [4] = '{8'd255, 8'd200, 8'd0, 8'd30};
  int gtab [4][4] = '{'{255, 82, 0, 18}, '{255, 71, 0, 19},
                      '{255, 117, 0, 20}, '{255, 50, 0, 20}};

  logic d_de [3];
  int   d_g [3], d_x [3], d_y [3];
  int   last_g, last_x, last_y;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0d, expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clr_model();
    for (int i = 0; i < 3; i++) begin
      d_de[i] = 1'b0; d_g[i] = 0; d_x[i] = 0; d_y[i] = 0;
    end
    last_g = 0; last_x = 0; last_y = 0;
  endtask

  task automatic cyc(input logic vs, input logic de, input int pix,
                     input int ex, input int ey, input logic ee);
    bus.i_vs    = vs;
    bus.data_de = de;
    bus.data_r  = pr[pix];
    bus.data_g  = pg[pix];
    bus.data_b  = pb[pix];
    for (int i = 2; i > 0; i--) begin
      d_de[i] = d_de[i-1]; d_g[i] = d_g[i-1]; d_x[i] = d_x[i-1]; d_y[i] = d_y[i-1];
    end
    d_de[0] = de; d_g[0] = gtab[exp_mode][pix]; d_x[0] = ex; d_y[0] = ey;
    tick();
    if (d_de[2]) begin
      last_g = d_g[2]; last_x = d_x[2]; last_y = d_y[2];
    end
    chk("o_de",    bus.o_de,    d_de[2]);
    chk("o_gray",  bus.o_gray,  last_g);
    chk("o_pix_x", bus.o_pix_x, last_x);
    chk("o_pix_y", bus.o_pix_y, last_y);
    chk("o_sof",   bus.o_sof,   d_de[2] && d_x[2] == 0 && d_y[2] == 0);
    chk("o_eol",   bus.o_eol,   d_de[2] && d_x[2] == H - 1);
    chk("o_err",   bus.o_err,   ee);
    n_sof  += int'(bus.o_sof);
    n_eol  += int'(bus.o_eol);
    n_errp += int'(bus.o_err);
  endtask

  task automatic line(input int y, input int n);
    for (int x = 0; x < n; x++) cyc(1'b0, 1'b1, (x + y) % 4, x, y, 1'b0);
  endtask

  task automatic frame(input int m, input logic [1:0] later_mode);
    n_sof = 0; n_eol = 0; n_errp = 0;
    cyc(1'b1, 1'b0, 0, 0, 0, 1'b0);
    exp_mode   = m;
    bus.i_mode = later_mode;
    for (int y = 0; y < V; y++) line(y, H);
    repeat (3) cyc(1'b0, 1'b0, 0, 0, 0, 1'b0);
    chk("sof_count", n_sof, 1);
    chk("eol_count", n_eol, V);
    chk("err_count", n_errp, 0);
  endtask

  initial begin
    bus.i_vs = 1'b0; bus.data_de = 1'b0; bus.i_mode = 2'd0;
    bus.data_r = '0; bus.data_g = '0; bus.data_b = '0;
    exp_mode = 0;
    clr_model();

    // Reset state
    rst_n = 1'b0;
    tick(); tick();
    chk("rst_o_de",  bus.o_de,    0);
    chk("rst_gray",  bus.o_gray,  0);
    chk("rst_x",     bus.o_pix_x, 0);
    chk("rst_y",     bus.o_pix_y, 0);
    chk("rst_sof",   bus.o_sof,   0);
    chk("rst_eol",   bus.o_eol,   0);
    chk("rst_err",   bus.o_err,   0);
    rst_n = 1'b1;
    repeat (2) cyc(1'b0, 1'b0, 0, 0, 0, 1'b0);

    // Full frames in each mode; i_mode changed right after each vsync must not take effect
    frame(0, 2'd0);
    bus.i_mode = 2'd1;
    frame(1, 2'd2);
    frame(2, 2'd3);
    frame(3, 2'd0);

    // Short line on line 5, then vsync raised while at (10,3) coincident with a beat
    cyc(1'b1, 1'b0, 0, 0, 0, 1'b0);
    exp_mode = 0;
    for (int y = 0; y < 5; y++) line(y, H);
    line(5, 9);
    cyc(1'b0, 1'b0, 0, 0, 0, 1'b1);
    cyc(1'b0, 1'b0, 0, 0, 0, 1'b0);
    line(6, H);
    line(7, H);
    for (int y = 0; y < 3; y++) line(y, H);
    line(3, 10);
    bus.i_mode = 2'd2;
    cyc(1'b1, 1'b1, 1, 10, 3, 1'b1);
    exp_mode = 2;
    cyc(1'b0, 1'b1, 1, 0, 0, 1'b0);
    for (int x = 1; x < H; x++) cyc(1'b0, 1'b1, x % 4, x, 0, 1'b0);

    // Reset with two pixels in flight; mode returns to BT.601
    cyc(1'b0, 1'b1, 1, 0, 1, 1'b0);
    cyc(1'b0, 1'b1, 1, 1, 1, 1'b0);
    bus.data_de = 1'b0;
    rst_n = 1'b0;
    tick();
    clr_model();
    chk("mid_rst_o_de", bus.o_de,    0);
    chk("mid_rst_gray", bus.o_gray,  0);
    chk("mid_rst_x",    bus.o_pix_x, 0);
    chk("mid_rst_y",    bus.o_pix_y, 0);
    chk("mid_rst_err",  bus.o_err,   0);
    rst_n = 1'b1;
    exp_mode = 0;
    repeat (3) cyc(1'b0, 1'b0, 0, 0, 0, 1'b0);
    cyc(1'b0, 1'b1, 1, 0, 0, 1'b0);
    cyc(1'b0, 1'b0, 0, 0, 0, 1'b1);
    repeat (3) cyc(1'b0, 1'b0, 0, 0, 0, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
